// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage floating-point path select, round and pack pipeline
//
// Stage 1 picks the addition or subtraction alignment result and forms the
// guard/sticky pair; stage 2 rounds, detects overflow and packs the result.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop every in-flight operation
//   valid_i / ready_o      upstream handshake
//   op_sub_i, sign_i, rm_i operation path, result sign, rounding mode
//   norm_exp_i/norm_man_i  normalised exponent/mantissa (subtraction path)
//   raw_exp_i/raw_man_i    pre-normalisation exponent/mantissa (addition path)
//   shift_i, grs_i         normalisation shift, guard/round/sticky bits
//   denorm_i               operands were denormal
//   valid_o / ready_i      downstream handshake
//   result_o               {sign, exponent, mantissa}
//   overflow_o, inexact_o  exception flags aligned with result_o
module fp_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     op_sub_i,
    input  logic                     sign_i,
    input  logic [2:0]               rm_i,
    input  logic [EXP_W-1:0]         norm_exp_i,
    input  logic [MAN_W-1:0]         norm_man_i,
    input  logic [EXP_W-1:0]         raw_exp_i,
    input  logic [MAN_W+1:0]         raw_man_i,
    input  logic [4:0]               shift_i,
    input  logic [2:0]               grs_i,
    input  logic                     denorm_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic                     overflow_o,
    output logic                     inexact_o
);

    localparam int SUM_W = EXP_W + 1 + MAN_W;
    localparam int RES_W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Stage 1 registers
    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [2:0]       s1_rm_q;
    logic [EXP_W:0]   s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0] s1_man_q, s1_man_d;
    logic             s1_g_q, s1_g_d;
    logic             s1_s_q, s1_s_d;

    // Stage 2 (output) registers
    logic             s2_valid_q;
    logic [RES_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             inx_q, inx_d;

    logic s2_adv;
    logic s1_load;
    logic in_xfer;

    assign s2_adv  = !s2_valid_q | ready_i;
    assign s1_load = !s1_valid_q | s2_adv;
    assign ready_o = s1_load;
    assign in_xfer = valid_i & s1_load;

    // Stage 1 path selection
    always_comb begin
        s1_exp_d = {1'b0, raw_exp_i};
        s1_man_d = raw_man_i[MAN_W-1:0];
        s1_g_d   = grs_i[1];
        s1_s_d   = grs_i[0];
        if (op_sub_i) begin
            s1_exp_d = {1'b0, norm_exp_i};
            s1_man_d = norm_man_i;
            if (shift_i == 5'd0) begin
                s1_g_d = grs_i[2];
                s1_s_d = grs_i[1] | grs_i[0];
            end else if (shift_i == 5'd1) begin
                s1_g_d = grs_i[1];
                s1_s_d = grs_i[0];
            end else begin
                s1_g_d = 1'b0;
                s1_s_d = 1'b0;
            end
        end else if (raw_man_i[MAN_W+1]) begin
            // Mantissa carried out: shift right one, the dropped bit becomes guard
            s1_exp_d = {1'b0, raw_exp_i} + {{EXP_W{1'b0}}, 1'b1};
            s1_man_d = raw_man_i[MAN_W:1];
            s1_g_d   = raw_man_i[0];
            s1_s_d   = |grs_i;
        end else if (denorm_i && raw_man_i[MAN_W]) begin
            // Denormal sum grew into the normal range
            s1_exp_d = {1'b0, raw_exp_i} + {{EXP_W{1'b0}}, 1'b1};
            s1_g_d   = grs_i[2];
            s1_s_d   = grs_i[1] | grs_i[0];
        end
    end

    // Stage 2 rounding and packing
    logic             inc;
    logic             rnd_any;
    logic             to_inf;
    logic [SUM_W-1:0] sum;
    logic [EXP_W:0]   rexp;

    always_comb begin
        rnd_any = s1_g_q | s1_s_q;
        case (s1_rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign_q & rnd_any;
            RM_RUP:  inc = !s1_sign_q & rnd_any;
            RM_RMM:  inc = s1_g_q;
            default: inc = s1_g_q & (s1_s_q | s1_man_q[0]);
        endcase

        // Mantissa carry ripples straight into the exponent field
        sum  = {s1_exp_q, s1_man_q} + {{(SUM_W-1){1'b0}}, inc};
        rexp = sum[SUM_W-1:MAN_W];
        ovf_d = rexp >= {1'b0, {EXP_W{1'b1}}};

        case (s1_rm_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_sign_q;
            RM_RUP:  to_inf = !s1_sign_q;
            default: to_inf = 1'b1;
        endcase

        if (ovf_d && to_inf) begin
            result_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ovf_d) begin
            result_d = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            result_d = {s1_sign_q, rexp[EXP_W-1:0], sum[MAN_W-1:0]};
        end
        inx_d = rnd_any | ovf_d;
    end

    // Control and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= valid_i;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                inx_q    <= inx_d;
            end
        end
    end

    // Stage 1 datapath, meaningful only alongside s1_valid_q
    always_ff @(posedge clk_i) begin
        if (in_xfer) begin
            s1_sign_q <= sign_i;
            s1_rm_q   <= rm_i;
            s1_exp_q  <= s1_exp_d;
            s1_man_q  <= s1_man_d;
            s1_g_q    <= s1_g_d;
            s1_s_q    <= s1_s_d;
        end
    end

    assign valid_o    = s2_valid_q;
    assign result_o   = result_q;
    assign overflow_o = ovf_q;
    assign inexact_o  = inx_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - directed self-checking bench for fp_round_pipe
module tb_fp_round_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic        op_sub;
    logic        sign;
    logic [2:0]  rm;
    logic [7:0]  norm_exp;
    logic [22:0] norm_man;
    logic [7:0]  raw_exp;
    logic [24:0] raw_man;
    logic [4:0]  shift;
    logic [2:0]  grs;
    logic        denorm;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic        overflow;
    logic        inexact;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .op_sub_i   (op_sub),
        .sign_i     (sign),
        .rm_i       (rm),
        .norm_exp_i (norm_exp),
        .norm_man_i (norm_man),
        .raw_exp_i  (raw_exp),
        .raw_man_i  (raw_man),
        .shift_i    (shift),
        .grs_i      (grs),
        .denorm_i   (denorm),
        .valid_o    (valid_out),
        .ready_i    (ready_in),
        .result_o   (result),
        .overflow_o (overflow),
        .inexact_o  (inexact)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic s_sub, input logic s_sign, input logic [2:0] s_rm,
                          input logic [7:0] s_nexp, input logic [22:0] s_nman,
                          input logic [7:0] s_rexp, input logic [24:0] s_rman,
                          input logic [4:0] s_shift, input logic [2:0] s_grs, input logic s_den);
        op_sub   = s_sub;
        sign     = s_sign;
        rm       = s_rm;
        norm_exp = s_nexp;
        norm_man = s_nman;
        raw_exp  = s_rexp;
        raw_man  = s_rman;
        shift    = s_shift;
        grs      = s_grs;
        denorm   = s_den;
    endtask

    // One operation through an empty pipe; inputs already set via set_op.
    task automatic run_op(input string tag, input logic [31:0] exp_res,
                          input logic chk_ovf, input logic exp_ovf, input logic exp_inx);
        ready_in = 1'b1;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check({tag, " lat1 valid"}, 64'(valid_out), 64'd0);
        @(negedge clk);
        check({tag, " lat2 valid"}, 64'(valid_out), 64'd1);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        if (chk_ovf) check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, " inexact"}, 64'(inexact), 64'(exp_inx));
    endtask

    logic [31:0] bp_exp [4];
    logic [22:0] bp_man [4];
    int          in_idx;
    int          out_idx;
    logic        saw_low;
    logic        stale;

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        set_op(0, 0, 3'b000, 8'h00, 23'h0, 8'h00, 25'h0, 5'd0, 3'b000, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset valid_o", 64'(valid_out), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset inexact", 64'(inexact), 64'd0);
        check("reset ready_o", 64'(ready_out), 64'd1);

        // Addition with mantissa carry-out
        set_op(0, 0, 3'b000, 8'h00, 23'h0, 8'h7F, 25'h1800001, 5'd0, 3'b000, 0);
        run_op("add carry", 32'h40400000, 1, 0, 1);
        // Denormal sum reaching the normal range, RNE tie rounds up (lsb odd)
        set_op(0, 0, 3'b000, 8'h00, 23'h0, 8'h00, 25'h0800003, 5'd0, 3'b100, 1);
        run_op("add denorm", 32'h00800004, 1, 0, 1);
        // Plain addition path, RUP
        set_op(0, 0, 3'b011, 8'h00, 23'h0, 8'h10, 25'h0400005, 5'd0, 3'b011, 0);
        run_op("add plain rup", 32'h08400006, 1, 0, 1);
        // RNE ties
        set_op(1, 0, 3'b000, 8'h7F, 23'h000001, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("rne tie odd", 32'h3F800002, 1, 0, 1);
        set_op(1, 0, 3'b000, 8'h7F, 23'h000000, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("rne tie even", 32'h3F800000, 1, 0, 1);
        // Reserved rounding mode behaves as RNE
        set_op(1, 0, 3'b101, 8'h7F, 23'h000001, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("rm101 as rne", 32'h3F800002, 1, 0, 1);
        // Shift 1 and shift >=2 guard/sticky selection
        set_op(1, 0, 3'b100, 8'h7F, 23'h000000, 8'h00, 25'h0, 5'd1, 3'b010, 0);
        run_op("shift1 rmm", 32'h3F800001, 1, 0, 1);
        set_op(1, 0, 3'b011, 8'h7F, 23'h000000, 8'h00, 25'h0, 5'd2, 3'b111, 0);
        run_op("shift2 exact", 32'h3F800000, 1, 0, 0);
        // RDN on a negative value rounds magnitude up
        set_op(1, 1, 3'b010, 8'h7F, 23'h000000, 8'h00, 25'h0, 5'd0, 3'b001, 0);
        run_op("rdn neg", 32'hBF800001, 1, 0, 1);
        // Mantissa carry into exponent
        set_op(1, 0, 3'b000, 8'h7F, 23'h7FFFFF, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("man carry", 32'h40000000, 1, 0, 1);
        // Overflow cases
        set_op(1, 0, 3'b000, 8'hFE, 23'h7FFFFF, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("ovf rne", 32'h7F800000, 1, 1, 1);
        set_op(1, 0, 3'b001, 8'hFE, 23'h7FFFFF, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("rtz max", 32'h7F7FFFFF, 0, 0, 1);
        set_op(1, 1, 3'b010, 8'hFE, 23'h7FFFFF, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        run_op("ovf rdn neg", 32'hFF800000, 1, 1, 1);
        set_op(1, 0, 3'b001, 8'hFF, 23'h000000, 8'h00, 25'h0, 5'd0, 3'b000, 0);
        run_op("ovf rtz", 32'h7F7FFFFF, 1, 1, 1);
        @(negedge clk);

        // Backpressure: four ops, ready_i low for the first three cycles
        for (int k = 0; k < 4; k++) begin
            bp_man[k] = 23'(k * 32'h1111 + 1);
            bp_exp[k] = 32'h3F800000 | 32'(bp_man[k]);
        end
        in_idx = 0; out_idx = 0; saw_low = 1'b0;
        for (int c = 0; c < 30 && out_idx < 4; c++) begin
            ready_in = (c >= 3);
            if (in_idx < 4) begin
                set_op(1, 0, 3'b001, 8'h7F, bp_man[in_idx], 8'h00, 25'h0, 5'd0, 3'b000, 0);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (!ready_out) saw_low = 1'b1;
            if (valid_out && !ready_in) check("bp stall hold", 64'(result), 64'(bp_exp[out_idx]));
            if (valid_out && ready_in) begin
                check("bp result order", 64'(result), 64'(bp_exp[out_idx]));
                out_idx++;
            end
            if (valid_in && ready_out) in_idx++;
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("bp ready_o dropped", 64'(saw_low), 64'd1);
        check("bp outputs count", 64'(out_idx), 64'd4);
        @(negedge clk);
        @(negedge clk);
        check("bp drained", 64'(valid_out), 64'd0);

        // Flush with both stages valid and a new input in the same cycle
        ready_in = 1'b0;
        set_op(1, 0, 3'b000, 8'h7F, 23'h000001, 8'h00, 25'h0, 5'd0, 3'b100, 0);
        valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("flush pre valid", 64'(valid_out), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        check("flush valid_o", 64'(valid_out), 64'd0);
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid_out) stale = 1'b1;
        end
        check("flush no stale", 64'(stale), 64'd0);

        // Reset mid-stream with both stages valid
        ready_in = 1'b0;
        valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst pre valid", 64'(valid_out), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        check("rst valid_o", 64'(valid_out), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst inexact", 64'(inexact), 64'd0);
        check("rst ready_o", 64'(ready_out), 64'd1);
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid_out) stale = 1'b1;
        end
        check("rst no stale", 64'(stale), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
